// File: rtl/joy_serializer_pkg.sv
// Shared definitions for the joystick shift-register chain (serializer and decoder).
// Word layout is MXYZ SACB RLDU, MSB first, active low.
package joy_pkg;

  localparam int JOY_BITS  = 12;
  localparam int JOY_FRAME = 2 * JOY_BITS;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } joy_state_e;

  // Bit positions within one joystick word
  localparam int JOY_IDX_U = 0;
  localparam int JOY_IDX_D = 1;
  localparam int JOY_IDX_L = 2;
  localparam int JOY_IDX_R = 3;
  localparam int JOY_IDX_B = 4;
  localparam int JOY_IDX_C = 5;
  localparam int JOY_IDX_A = 6;
  localparam int JOY_IDX_S = 7;
  localparam int JOY_IDX_Z = 8;
  localparam int JOY_IDX_Y = 9;
  localparam int JOY_IDX_X = 10;
  localparam int JOY_IDX_M = 11;

endpackage

// File: rtl/joy_serializer_if.sv
// Three-wire joystick chain between host (decoder) and device (serializer).
interface joy_serializer_if;

  logic joy_load_n;
  logic joy_clk;
  logic joy_data;

  modport master (output joy_load_n, output joy_clk, input joy_data);
  modport slave  (input joy_load_n, input joy_clk, output joy_data);

endinterface

// File: rtl/joy_serializer_sync_edge.sv
// Multi-flop synchroniser for an asynchronous level, with registered level and
// rising-edge pulse; the pulse is aligned with the cycle the synced level rises.
module sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic level_o,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rise_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      rise_q <= sync_q[SYNC_STAGES-2] & ~sync_q[SYNC_STAGES-1];
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = rise_q;

endmodule

// File: rtl/joy_serializer.sv
// Device end of the joystick chain: captures two words on load, shifts them out
// MSB-first on each host joy_clk rising edge, then drives the fill level.
module joy_serializer
  import joy_pkg::*;
#(
  parameter int   NBITS       = JOY_BITS,
  parameter int   SYNC_STAGES = 2,
  parameter logic FILL        = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  joy_serializer_if.slave  joy,
  input  logic [NBITS-1:0] joy1_i,
  input  logic [NBITS-1:0] joy2_i,
  output logic             frame_done,
  output logic             overrun,
  output logic [4:0]       bit_cnt
);

  localparam int         FRAME     = 2 * NBITS;
  localparam logic [4:0] FRAME_CNT = 5'(FRAME);

  logic load_n_lvl;
  logic load_rel_unused;
  logic joy_clk_lvl_unused;
  logic shift_stb;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_load_sync (
    .clk     (clk),
    .rst     (rst),
    .async_i (joy.joy_load_n),
    .level_o (load_n_lvl),
    .rise_o  (load_rel_unused)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_clk_sync (
    .clk     (clk),
    .rst     (rst),
    .async_i (joy.joy_clk),
    .level_o (joy_clk_lvl_unused),
    .rise_o  (shift_stb)
  );

  joy_state_e       state_q;
  logic [FRAME-1:0] sr_q;
  logic [4:0]       cnt_q;
  logic             frame_done_q;
  logic             overrun_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      sr_q         <= {FRAME{FILL}};
      cnt_q        <= '0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      // Load has priority over everything, including a coincident shift strobe
      if (!load_n_lvl) begin
        state_q   <= ST_LOAD;
        sr_q      <= {joy1_i, joy2_i};
        cnt_q     <= '0;
        overrun_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: ;
          ST_LOAD: state_q <= ST_SHIFT;
          ST_SHIFT: begin
            if (shift_stb) begin
              sr_q  <= {sr_q[FRAME-2:0], FILL};
              cnt_q <= cnt_q + 5'd1;
              if (cnt_q == FRAME_CNT - 5'd1) begin
                frame_done_q <= 1'b1;
                state_q      <= ST_DONE;
              end
            end
          end
          ST_DONE: begin
            if (shift_stb) overrun_q <= 1'b1;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign joy.joy_data = sr_q[FRAME-1];
  assign frame_done   = frame_done_q;
  assign overrun      = overrun_q;
  assign bit_cnt      = cnt_q;

endmodule

// File: doc/joy_serializer.md
Name: joy_serializer

Overview:
- Emulates the board's joystick shift-register chain: the device end of the joy_load_n / joy_clk / joy_data interface whose host end is the joystick decoder.
- Captures two 12-bit active-low joystick words (MXYZ SACB RLDU) on a load pulse, then shifts them out MSB-first, one bit per joy_clk rising edge.
- Used as a bench/loopback target for the board test core and as a joystick source for cores without a physical shifter.

Parameters:
- NBITS, 12, bits per joystick word; frame length is 2*NBITS.
- SYNC_STAGES, 2, flip-flop stages on joy_clk and joy_load_n; minimum 2.
- FILL, 1'b1, value shifted in behind the frame and driven after it ends (inactive level).

Ports:
- clk  in  1  system clock; must be at least 4x the joy_clk frequency.
- rst  in  1  asynchronous, active-high reset.
- joy_load_n  in  1  asynchronous from host; low = parallel load.
- joy_clk  in  1  asynchronous from host; rising edge = shift.
- joy_data  out  1  serial data to host.
- joy1_i  in  NBITS  joystick 1 word, active low.
- joy2_i  in  NBITS  joystick 2 word, active low.
- frame_done  out  1  one-clk pulse when the last frame bit has been shifted past.
- overrun  out  1  sticky; set by any joy_clk edge after the frame is exhausted, cleared by the next load.
- bit_cnt  out  5  bits shifted since the last load, saturating at 2*NBITS.

Behaviour:
- Reset (async, rst=1):
  - Shift register all FILL; joy_data=FILL.
  - bit_cnt=0, frame_done=0, overrun=0, state=IDLE.
- Input conditioning:
  - joy_load_n and joy_clk each pass through SYNC_STAGES flops.
  - Rising edge of synced joy_clk = shift strobe.
  - Synced load_n low = load level.
- Shift register: 2*NBITS wide, laid out {joy1_i, joy2_i}; joy_data is always its MSB, registered.
- States:
  - IDLE: wait for load.
  - LOAD: while load is low, reload {joy1_i, joy2_i} every clk; bit_cnt=0; overrun=0; shift strobes ignored. Load going high -> SHIFT.
  - SHIFT: each strobe shifts left by 1, inserting FILL at the LSB, and increments bit_cnt. The strobe that takes bit_cnt to 2*NBITS pulses frame_done and goes to DONE.
  - DONE: joy_data=FILL; each further strobe sets overrun; bit_cnt holds at 2*NBITS.
- Load asserted in any state -> LOAD immediately. Mid-frame aborts are legal: no frame_done, counters restart.
- Simultaneous load and strobe in the same clk: load wins, the strobe is discarded.
- Latency:
  - joy_data shows the new bit SYNC_STAGES+1 clk after a joy_clk rising edge at the pin.
  - The first bit (joy1_i[NBITS-1]) is valid SYNC_STAGES+1 clk after joy_load_n falls.
  - The host must sample no earlier than that after its edge.
- joy1_i/joy2_i changing during SHIFT has no effect on the frame in flight.
- Glitches shorter than 1 clk on joy_clk may be missed; no filtering beyond synchronisation.

Decomposition:
- Shared package joy_pkg:
  - JOY_BITS=12 and JOY_FRAME=2*JOY_BITS.
  - State encoding (IDLE, LOAD, SHIFT, DONE).
  - Bit index constants for the MXYZ SACB RLDU layout, shared with the decoder.
- One sub-module, sync_edge: SYNC_STAGES-flop synchroniser with registered level and rising-edge pulse outputs, async active-high reset. Instantiated for joy_clk and joy_load_n.

Test Plan:
- Reset then release with no host activity -> joy_data=1, bit_cnt=0, overrun=0, frame_done never pulses.
- joy1_i=12'hA5C, joy2_i=12'h3F0; load pulse, then 24 joy_clk edges at clk/8 -> serial stream 1010_0101_1100_0011_1111_0000 MSB-first; frame_done pulses once after edge 24; bit_cnt=24.
- Same frame, then 3 extra edges -> joy_data=1 on all three, overrun=1, bit_cnt=24. Next load -> overrun=0, joy_data=joy1_i[11].
- Load after 10 edges (mid-frame) with new joy1_i=12'h000 -> joy_data=0 within SYNC_STAGES+1 clk, bit_cnt=0, no frame_done.
- joy1_i changed from 12'hFFF to 12'h000 after edge 5 -> remaining joy1 bits still all 1.
- Loopback against the joystick decoder at joy_clk = clk/6 with random words for 1000 frames -> decoder outputs equal joy1_i/joy2_i every frame.
